// File: rtl/timer_pkg.sv
// Shared types and register map for the timer_array peripheral.
package timer_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_CNT, ST_INT} state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PSC_LO  = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // Packed so the struct reads back directly as CTRL[7:0].
  typedef struct packed {
    logic [3:0] psc;
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: CTRL/PRESET/COUNT/STATUS registers,
// 4-bit prescaler and the IDLE/LOAD/CNT/INT sequencer.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [1:0]  reg_sel,
  input  logic [31:0] din,
  output logic [31:0] rdata,
  output logic        irq
);

  state_e             state, state_nxt;
  ctrl_t              ctrl, ctrl_nxt, ctrl_wr;
  logic [CNT_W-1:0]   preset, count, count_nxt;
  logic [3:0]         psc_cnt, psc_cnt_nxt;
  logic               pending, pend_set;
  logic               wr_ctrl, wr_preset, w1c, en_eff;

  assign wr_ctrl   = we && (reg_sel == REG_CTRL);
  assign wr_preset = we && (reg_sel == REG_PRESET);
  assign w1c       = we && (reg_sel == REG_STATUS) && din[0];

  assign ctrl_wr = '{psc:  din[CTRL_PSC_LO +: 4],
                     im:   din[CTRL_IM],
                     mode: din[CTRL_MODE_LO +: 2],
                     en:   din[CTRL_EN]};

  // The sequencer sees a CTRL value being written this cycle, so a start
  // write enters LOAD on the same edge.
  assign en_eff = wr_ctrl ? ctrl_wr.en : ctrl.en;

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    psc_cnt_nxt = psc_cnt;
    pend_set    = 1'b0;
    ctrl_nxt    = wr_ctrl ? ctrl_wr : ctrl;
    case (state)
      ST_IDLE: if (en_eff) state_nxt = ST_LOAD;
      ST_LOAD: begin
        count_nxt   = preset;
        psc_cnt_nxt = '0;
        state_nxt   = ST_CNT;
      end
      ST_CNT: begin
        if (!en_eff) begin
          state_nxt = ST_IDLE;
        end else if (count == '0) begin
          state_nxt = ST_INT;
          pend_set  = 1'b1;
        end else if (psc_cnt == ctrl.psc) begin
          count_nxt   = count - 1'b1;
          psc_cnt_nxt = '0;
        end else begin
          psc_cnt_nxt = psc_cnt + 4'd1;
        end
      end
      ST_INT: begin
        // Held set through INT so a W1C landing here cannot win.
        pend_set = 1'b1;
        if (ctrl.mode == MODE_AUTO) begin
          state_nxt = ST_LOAD;
        end else begin
          if (!wr_ctrl) ctrl_nxt.en = 1'b0;
          state_nxt = ctrl_nxt.en ? ST_LOAD : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ctrl    <= '0;
      preset  <= '0;
      count   <= '0;
      psc_cnt <= '0;
      pending <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctrl    <= ctrl_nxt;
      count   <= count_nxt;
      psc_cnt <= psc_cnt_nxt;
      if (wr_preset) preset <= din[CNT_W-1:0];
      if (pend_set)  pending <= 1'b1;
      else if (w1c)  pending <= 1'b0;
    end
  end

  always_comb begin
    rdata = '0;
    case (reg_sel)
      REG_CTRL:   rdata[7:0]       = ctrl;
      REG_PRESET: rdata[CNT_W-1:0] = preset;
      REG_COUNT:  rdata[CNT_W-1:0] = count;
      default:    rdata[0]         = pending;
    endcase
  end

  assign irq = pending & ctrl.im;

endmodule

// File: rtl/timer_array.sv
// N_CH-channel timer peripheral: address decode, read mux, irq vector.
module timer_array
  import timer_pkg::*;
#(
  parameter  int N_CH   = 2,
  parameter  int CNT_W  = 32,
  localparam int ADDR_W = $clog2(N_CH) + 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              WE,
  input  logic [31:0]       Din,
  output logic [31:0]       Dout,
  output logic [N_CH-1:0]   irq,
  output logic              irq_any
);

  logic [N_CH-1:0][31:0] rdata;
  logic [31:0]           ch_idx;

  if (ADDR_W > 2) begin : g_sel
    assign ch_idx = 32'(Addr[ADDR_W-1:2]);
  end else begin : g_one
    assign ch_idx = '0;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    timer_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we      (WE && (ch_idx == 32'(i))),
      .reg_sel (Addr[1:0]),
      .din     (Din),
      .rdata   (rdata[i]),
      .irq     (irq[i])
    );
  end

  // Indices with no channel behind them fall through to zero.
  always_comb begin
    Dout = '0;
    for (int i = 0; i < N_CH; i++)
      if (ch_idx == 32'(i)) Dout = rdata[i];
  end

  assign irq_any = |irq;

endmodule
